// File: rtl/polara_loopback_pkg.sv
// polara_loopback_pkg: shared state encoding, NoC ids and header field defaults
package polara_loopback_pkg;

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [1:0] NOC_NONE = 2'd0;
    localparam logic [1:0] NOC1     = 2'd1;
    localparam logic [1:0] NOC2     = 2'd2;
    localparam logic [1:0] NOC3     = 2'd3;

    localparam int LEN_LSB_DEF = 22;
    localparam int LEN_W_DEF   = 8;

    // round-robin successor of a NoC id, noc3 wraps to noc1
    function automatic logic [1:0] next_noc(input logic [1:0] id);
        return (id == NOC3) ? NOC1 : id + 2'd1;
    endfunction

endpackage

// File: rtl/polara_rr_pick3.sv
// polara_rr_pick3: 3-way rotating-priority picker with optional fixed order
module polara_rr_pick3
    import polara_loopback_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    input  logic       fixed,
    output logic [2:0] gnt
);

    logic [1:0] start;
    logic [5:0] dbl;
    logic [2:0] rot;
    logic [2:0] pr;
    logic [5:0] back;

    // rotate requests so the highest-priority slot sits at bit 0, pick, rotate back
    always_comb begin
        start = (fixed || ptr == NOC_NONE) ? 2'd0 : ptr - 2'd1;
        dbl   = {req, req};
        rot   = dbl[start +: 3];
        pr    = rot[0] ? 3'b001 : rot[1] ? 3'b010 : rot[2] ? 3'b100 : 3'b000;
        back  = {3'b000, pr} << start;
        gnt   = back[2:0] | back[5:3];
    end

endmodule

// File: rtl/polara_loopback_noc_arb.sv
// polara_loopback_noc_arb: packet-atomic arbiter of three NoC sources onto one link
module polara_loopback_noc_arb
    import polara_loopback_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int LEN_LSB = LEN_LSB_DEF,
    parameter int LEN_W   = LEN_W_DEF,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 16
) (
    input  logic              chipset_clk,
    input  logic              chip_rst_n,
    input  logic              prio_mode,
    input  logic [DATA_W-1:0] src_data_noc1,
    input  logic [DATA_W-1:0] src_data_noc2,
    input  logic [DATA_W-1:0] src_data_noc3,
    input  logic              src_val_noc1,
    input  logic              src_val_noc2,
    input  logic              src_val_noc3,
    output logic              src_rdy_noc1,
    output logic              src_rdy_noc2,
    output logic              src_rdy_noc3,
    output logic [DATA_W-1:0] link_data,
    output logic              link_val,
    input  logic              link_rdy,
    output logic [1:0]        link_noc_id,
    output logic [CNT_W-1:0]  pkt_cnt_noc1,
    output logic [CNT_W-1:0]  pkt_cnt_noc2,
    output logic [CNT_W-1:0]  pkt_cnt_noc3,
    output logic              timeout_err
);

    localparam int SW = $clog2(TIMEOUT + 1);

    state_t           state;
    logic [1:0]       rr_ptr;
    logic [1:0]       grant;
    logic [1:0]       sel;
    logic [1:0]       pick_id;
    logic [2:0]       pick;
    logic [LEN_W-1:0] remaining;
    logic [LEN_W-1:0] len;
    logic [SW-1:0]    stall_cnt;
    logic             hs;
    logic             done;

    polara_rr_pick3 u_pick (
        .req   ({src_val_noc3, src_val_noc2, src_val_noc1}),
        .ptr   (rr_ptr),
        .fixed (prio_mode),
        .gnt   (pick)
    );

    // source selection and zero-latency link mux, forced idle while reset is low
    always_comb begin
        pick_id      = pick[0] ? NOC1 : pick[1] ? NOC2 : pick[2] ? NOC3 : NOC_NONE;
        sel          = !chip_rst_n ? NOC_NONE : (state == BUSY) ? grant : pick_id;
        link_noc_id  = sel;
        link_data    = sel == NOC1 ? src_data_noc1 : sel == NOC2 ? src_data_noc2 :
                       sel == NOC3 ? src_data_noc3 : '0;
        link_val     = sel == NOC1 ? src_val_noc1 : sel == NOC2 ? src_val_noc2 :
                       sel == NOC3 ? src_val_noc3 : 1'b0;
        src_rdy_noc1 = link_rdy && sel == NOC1;
        src_rdy_noc2 = link_rdy && sel == NOC2;
        src_rdy_noc3 = link_rdy && sel == NOC3;
        hs           = link_val && link_rdy;
        len          = link_data[LEN_LSB +: LEN_W];
        done         = hs && ((state == IDLE) ? len == '0 : remaining == LEN_W'(1));
    end

    // packet framing, grant hold, round-robin pointer and per-NoC packet counters
    always_ff @(posedge chipset_clk or negedge chip_rst_n) begin
        if (!chip_rst_n) begin
            state        <= IDLE;
            rr_ptr       <= NOC1;
            grant        <= NOC_NONE;
            remaining    <= '0;
            pkt_cnt_noc1 <= '0;
            pkt_cnt_noc2 <= '0;
            pkt_cnt_noc3 <= '0;
        end else if (hs) begin
            if (done) begin
                state  <= IDLE;
                grant  <= NOC_NONE;
                rr_ptr <= next_noc(sel);
                if (sel == NOC1) pkt_cnt_noc1 <= pkt_cnt_noc1 + CNT_W'(1);
                if (sel == NOC2) pkt_cnt_noc2 <= pkt_cnt_noc2 + CNT_W'(1);
                if (sel == NOC3) pkt_cnt_noc3 <= pkt_cnt_noc3 + CNT_W'(1);
            end else if (state == IDLE) begin
                state     <= BUSY;
                grant     <= sel;
                remaining <= len;
            end else begin
                remaining <= remaining - LEN_W'(1);
            end
        end
    end

    // stall watchdog: counts handshake-free BUSY cycles, flag is sticky until reset
    always_ff @(posedge chipset_clk or negedge chip_rst_n) begin
        if (!chip_rst_n) begin
            stall_cnt   <= '0;
            timeout_err <= 1'b0;
        end else if (state == BUSY && !hs) begin
            stall_cnt <= (stall_cnt == SW'(TIMEOUT - 1)) ? stall_cnt : stall_cnt + SW'(1);
            if (stall_cnt == SW'(TIMEOUT - 2)) timeout_err <= 1'b1;
        end else begin
            stall_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_polara_loopback_noc_arb.sv
// tb_polara_loopback_noc_arb: randomized scoreboard bench for the loopback NoC arbiter
module tb_polara_loopback_noc_arb;

    localparam int DW = 64;
    localparam int LL = 22;
    localparam int LW = 8;
    localparam int TO = 1024;
    localparam int CW = 16;

    typedef struct {
        logic [1:0]    id;
        logic [DW-1:0] d;
    } xfer_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          prio = 1'b0;
    logic          link_rdy = 1'b0;
    logic [DW-1:0] sd [3];
    logic          sv [3];
    logic [2:0]    srdy;
    logic [DW-1:0] link_data;
    logic          link_val;
    logic [1:0]    link_noc_id;
    logic [CW-1:0] pc [3];
    logic          timeout_err;

    polara_loopback_noc_arb dut (
        .chipset_clk   (clk),
        .chip_rst_n    (rst_n),
        .prio_mode     (prio),
        .src_data_noc1 (sd[0]),
        .src_data_noc2 (sd[1]),
        .src_data_noc3 (sd[2]),
        .src_val_noc1  (sv[0]),
        .src_val_noc2  (sv[1]),
        .src_val_noc3  (sv[2]),
        .src_rdy_noc1  (srdy[0]),
        .src_rdy_noc2  (srdy[1]),
        .src_rdy_noc3  (srdy[2]),
        .link_data     (link_data),
        .link_val      (link_val),
        .link_rdy      (link_rdy),
        .link_noc_id   (link_noc_id),
        .pkt_cnt_noc1  (pc[0]),
        .pkt_cnt_noc2  (pc[1]),
        .pkt_cnt_noc3  (pc[2]),
        .timeout_err   (timeout_err)
    );

    always #5 clk = ~clk;

    // reference model: per-source flit queues plus packet-level arbitration state
    logic [DW-1:0] fq [3][$];
    xfer_t         sb [$];
    int            owner, rem, rr, stall, exp_sel;
    int            mcnt [3];
    bit            terr, exp_hs, exp_val, mon_en;
    logic [DW-1:0] exp_data;
    logic [1:0]    exp_id;
    logic [2:0]    exp_rdy;
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add_pkt(input int s, input int len);
        logic [DW-1:0] f;
        f = {$urandom(), $urandom()};
        f[LL +: LW] = LW'(len);
        fq[s].push_back(f);
        for (int i = 0; i < len; i++) fq[s].push_back({$urandom(), $urandom()});
    endtask

    task automatic model_reset();
        owner = 0; rem = 0; rr = 0; stall = 0; terr = 0;
        exp_hs = 0; exp_val = 0; exp_data = '0; exp_id = 2'd0; exp_rdy = 3'b000; exp_sel = -1;
        for (int i = 0; i < 3; i++) begin
            mcnt[i] = 0;
            fq[i].delete();
        end
        sb.delete();
    endtask

    // one clock: retire last cycle's transfer in the model, drive new inputs, predict outputs
    task automatic step(input int vp, input int rp, input int pm);
        logic [DW-1:0] f;
        int            s, len, sel;
        bit            was_busy;
        @(posedge clk);
        #1;
        was_busy = owner != 0;
        if (exp_hs) begin
            s = exp_sel;
            f = fq[s].pop_front();
            if (owner == 0) begin
                len = int'(f[LL +: LW]);
                if (len == 0) begin
                    mcnt[s] = (mcnt[s] + 1) % (1 << CW);
                    rr = (s + 1) % 3;
                end else begin
                    owner = s + 1;
                    rem = len;
                end
            end else begin
                rem--;
                if (rem == 0) begin
                    mcnt[s] = (mcnt[s] + 1) % (1 << CW);
                    rr = (s + 1) % 3;
                    owner = 0;
                end
            end
        end
        if (was_busy && !exp_hs) begin
            stall++;
            if (stall == TO - 1) terr = 1;
        end else begin
            stall = 0;
        end
        for (int i = 0; i < 3; i++) begin
            sv[i] = fq[i].size() > 0 && $urandom_range(99) < vp;
            sd[i] = fq[i].size() > 0 ? fq[i][0] : {$urandom(), $urandom()};
        end
        link_rdy = $urandom_range(99) < rp;
        prio = (pm == 2) ? 1'($urandom_range(1)) : 1'(pm);
        sel = -1;
        if (owner != 0) sel = owner - 1;
        else for (int k = 0; k < 3; k++) begin
            int i;
            i = prio ? k : (rr + k) % 3;
            if (sv[i] && sel < 0) sel = i;
        end
        exp_sel  = sel;
        exp_val  = sel >= 0 && sv[sel];
        exp_data = sel >= 0 ? sd[sel] : '0;
        exp_id   = 2'(sel + 1);
        exp_rdy  = (sel >= 0 && link_rdy) ? 3'(1 << sel) : 3'b000;
        exp_hs   = exp_val && link_rdy;
        if (exp_hs) sb.push_back('{id: exp_id, d: sd[sel]});
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((fq[0].size() > 0 || fq[1].size() > 0 || fq[2].size() > 0 || exp_hs || owner != 0) && n < 400) begin
            step(100, 100, 0);
            n++;
        end
        if (n >= 400) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d cycles expected < 400", n);
        end
    endtask

    // monitor: per-cycle output checks and scoreboard pop on every link transfer
    always @(negedge clk) begin
        xfer_t x;
        if (mon_en) begin
            chk("link_val", 64'(link_val), 64'(exp_val));
            chk("link_noc_id", 64'(link_noc_id), 64'(exp_id));
            chk("link_data", link_data, exp_data);
            chk("src_rdy", 64'(srdy), 64'(exp_rdy));
            for (int i = 0; i < 3; i++) chk("pkt_cnt", 64'(pc[i]), 64'(mcnt[i]));
            chk("timeout_err", 64'(timeout_err), 64'(terr));
            if (link_val && link_rdy) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_empty: got transfer id %0d expected none", link_noc_id);
                end else begin
                    x = sb.pop_front();
                    chk("sb_id", 64'(link_noc_id), 64'(x.id));
                    chk("sb_data", link_data, x.d);
                end
            end
        end
    end

    task automatic chk_quiet(input string tag);
        chk({tag, "_val"}, 64'(link_val), 64'd0);
        chk({tag, "_rdy"}, 64'(srdy), 64'd0);
        chk({tag, "_id"}, 64'(link_noc_id), 64'd0);
        chk({tag, "_data"}, link_data, 64'd0);
    endtask

    initial begin
        mon_en = 0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            sv[i] = 1'b1;
            sd[i] = {$urandom(), $urandom()};
        end
        link_rdy = 1'b1;
        #12;
        chk_quiet("reset");
        for (int i = 0; i < 3; i++) chk("reset_cnt", 64'(pc[i]), 64'd0);
        chk("reset_timeout", 64'(timeout_err), 64'd0);
        for (int i = 0; i < 3; i++) sv[i] = 1'b0;
        link_rdy = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        mon_en = 1;

        add_pkt(0, 2);
        drain();
        @(negedge clk);
        chk("single_cnt1", 64'(pc[0]), 64'd1);

        for (int r = 0; r < 2; r++) for (int i = 0; i < 3; i++) add_pkt(i, 0);
        drain();

        add_pkt(0, 3);
        step(100, 100, 0);
        add_pkt(1, 0);
        repeat (5) step(100, 0, 0);
        drain();

        for (int r = 0; r < 6; r++) begin
            add_pkt(1, 0);
            add_pkt(2, 0);
        end
        repeat (6) step(100, 100, 1);
        drain();

        repeat (800) begin
            for (int i = 0; i < 3; i++)
                if (fq[i].size() < 8 && $urandom_range(7) == 0) add_pkt(i, $urandom_range(5));
            step(70, 70, 2);
        end
        drain();

        add_pkt(0, 2);
        step(100, 100, 0);
        repeat (TO + 3) step(100, 0, 0);
        drain();
        @(negedge clk);
        chk("timeout_sticky", 64'(timeout_err), 64'd1);

        add_pkt(0, 4);
        step(100, 100, 0);
        step(100, 100, 0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk_quiet("midrst");
        model_reset();
        for (int i = 0; i < 3; i++) sv[i] = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        add_pkt(0, 0);
        add_pkt(2, 1);
        drain();
        @(negedge clk);
        chk("postrst_cnt1", 64'(pc[0]), 64'd1);
        chk("postrst_timeout", 64'(timeout_err), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
